// File: rtl/tt_store_arb_pkg.sv
// Shared types and constants for the store-path arbiter and its credit logic.
package tt_store_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic REQ_US  = 1'b0;
  localparam logic REQ_IDX = 1'b1;

endpackage

// File: rtl/tt_credit_counter.sv
// Saturating credit counter: starts full, counts down on issue, up on return.
// Sticky err flags a return that arrives while the counter is already full.
module tt_credit_counter
  import tt_store_arb_pkg::*;
#(
  parameter int unsigned MAX = 4,
  localparam int unsigned W  = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         err
);

  logic [W-1:0] count_q, count_d;
  logic         err_q, err_d;

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    unique case ({inc, dec})
      2'b10: begin
        if (count_q == W'(MAX)) err_d = 1'b1;
        else                    count_d = count_q + 1'b1;
      end
      2'b01: begin
        if (count_q != '0) count_d = count_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= W'(MAX);
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: rtl/tt_store_arb.sv
// Two-requester store arbiter: round-robin between packets, packet-locked
// ownership, and credit-gated zero-latency issue to the downstream port.
module tt_store_arb
  import tt_store_arb_pkg::*;
#(
  parameter int unsigned STORE_CREDITS = 4,
  parameter int unsigned DATA_W        = 512,
  localparam int unsigned CW           = $clog2(STORE_CREDITS + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [1:0]             i_req_valid,
  input  logic [1:0]             i_req_last,
  input  logic [1:0][DATA_W-1:0] i_req_data,
  output logic [1:0]             o_req_ready,
  input  logic                   i_store_credit,
  output logic                   o_store_valid,
  output logic [DATA_W-1:0]      o_store_data,
  output logic                   o_store_owner,
  output logic [CW-1:0]          o_credits,
  output logic                   o_busy,
  output logic                   o_credit_err
);

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q, prio_d;
  logic   sel;
  logic   sel_valid;
  logic   fire;

  always_comb begin
    if (state_q == BURST) begin
      sel       = owner_q;
      sel_valid = i_req_valid[owner_q];
    end else begin
      if (&i_req_valid)             sel = prio_q;
      else if (i_req_valid[REQ_IDX]) sel = REQ_IDX;
      else                          sel = REQ_US;
      sel_valid = |i_req_valid;
    end
  end

  // Reset gates issue so a requester held valid through reset is never acked.
  assign fire = sel_valid && (o_credits != '0) && !i_reset;

  always_comb begin
    o_req_ready      = '0;
    o_req_ready[sel] = fire;
  end

  assign o_store_valid = fire;
  assign o_store_data  = i_req_data[sel];
  assign o_store_owner = fire & sel;
  assign o_busy        = (state_q == BURST);

  // In BURST sel is the owner, so one rule covers both states.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    if (fire) begin
      if (i_req_last[sel]) begin
        state_d = IDLE;
        prio_d  = ~sel;
      end else begin
        state_d = BURST;
        owner_d = sel;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  tt_credit_counter #(
    .MAX(STORE_CREDITS)
  ) u_credits (
    .clk  (i_clk),
    .rst  (i_reset),
    .inc  (i_store_credit),
    .dec  (fire),
    .count(o_credits),
    .err  (o_credit_err)
  );

endmodule

// File: tb/tb_tt_store_arb.sv
// Self-checking bench for tt_store_arb: directed scenarios plus randomized
// traffic, all compared against a packet-level reference model.
module tb_tt_store_arb;

  localparam int DW   = 64;
  localparam int CRED = 4;

  logic               clk;
  logic               i_reset;
  logic [1:0]         i_req_valid;
  logic [1:0]         i_req_last;
  logic [1:0][DW-1:0] i_req_data;
  logic [1:0]         o_req_ready;
  logic               i_store_credit;
  logic               o_store_valid;
  logic [DW-1:0]      o_store_data;
  logic               o_store_owner;
  logic [2:0]         o_credits;
  logic               o_busy;
  logic               o_credit_err;

  tt_store_arb #(
    .STORE_CREDITS(CRED),
    .DATA_W       (DW)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_req_valid   (i_req_valid),
    .i_req_last    (i_req_last),
    .i_req_data    (i_req_data),
    .o_req_ready   (o_req_ready),
    .i_store_credit(i_store_credit),
    .o_store_valid (o_store_valid),
    .o_store_data  (o_store_data),
    .o_store_owner (o_store_owner),
    .o_credits     (o_credits),
    .o_busy        (o_busy),
    .o_credit_err  (o_credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: packet lock, round-robin pointer, credit pool.
  int  m_cred;
  bit  m_lock;
  int  m_owner;
  int  m_prio;
  bit  m_err;
  int  issued[$];

  // Requester drivers.
  bit          want[2];
  bit          stall[2];
  bit          presented[2];
  int          plen[2];
  int          beat_idx[2];
  logic [DW-1:0] cur_data[2];
  bit          rand_mode;
  int          cmode;

  task automatic model_reset();
    m_cred  = CRED;
    m_lock  = 0;
    m_owner = 0;
    m_prio  = 0;
    m_err   = 0;
    issued.delete();
    for (int i = 0; i < 2; i++) begin
      want[i] = 0; stall[i] = 0; presented[i] = 0; beat_idx[i] = 0; plen[i] = 1;
    end
    rand_mode = 0;
    cmode     = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (!presented[i] && want[i] && !stall[i] && (!rand_mode || $urandom_range(0, 3) != 0)) begin
        presented[i] = 1;
        cur_data[i]  = {$urandom, $urandom};
      end
      i_req_valid[i] = presented[i];
      i_req_last[i]  = (beat_idx[i] == plen[i] - 1);
      i_req_data[i]  = cur_data[i];
    end
    case (cmode)
      0: i_store_credit = 1'b0;
      1: i_store_credit = 1'b1;
      2: i_store_credit = (m_cred < CRED);
      3: i_store_credit = (m_cred < CRED) ? 1'($urandom_range(0, 1))
                                          : ($urandom_range(0, 63) == 0);
      default: ;
    endcase
  endtask

  task automatic cycle();
    int         sel;
    bit         sv;
    bit         fire;
    logic [1:0] v;
    logic [1:0] exp_rdy;
    drive();
    @(negedge clk);
    v = i_req_valid;
    if (m_lock) begin
      sel = m_owner;
      sv  = v[m_owner];
    end else begin
      sv  = |v;
      sel = (v == 2'b11) ? m_prio : (v[1] ? 1 : 0);
    end
    fire    = sv && (m_cred > 0);
    exp_rdy = '0;
    if (fire) exp_rdy[sel] = 1'b1;
    check("store_valid", 64'(o_store_valid), 64'(fire));
    check("req_ready", 64'(o_req_ready), 64'(exp_rdy));
    check("store_owner", 64'(o_store_owner), fire ? 64'(sel) : 64'd0);
    if (fire) check("store_data", o_store_data, cur_data[sel]);
    check("credits", 64'(o_credits), 64'(m_cred));
    check("busy", 64'(o_busy), 64'(m_lock));
    check("credit_err", 64'(o_credit_err), 64'(m_err));
    @(posedge clk);
    m_cred = m_cred + int'(i_store_credit) - int'(fire);
    if (m_cred > CRED) begin
      m_cred = CRED;
      m_err  = 1;
    end
    if (fire) begin
      issued.push_back(sel);
      presented[sel] = 0;
      if (i_req_last[sel]) begin
        m_lock        = 0;
        m_prio        = 1 - sel;
        beat_idx[sel] = 0;
        if (rand_mode) plen[sel] = $urandom_range(1, 4);
      end else begin
        m_lock        = 1;
        m_owner       = sel;
        beat_idx[sel] = beat_idx[sel] + 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    i_reset        = 1'b1;
    i_req_valid    = '0;
    i_req_last     = '0;
    i_store_credit = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    i_reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp34[6];
    int exp36[5];
    exp34 = '{0, 0, 1, 1, 0, 0};
    exp36 = '{0, 0, 0, 0, 1};
    i_reset    = 1'b1;
    i_req_data = '0;
    model_reset();
    #2;
    check("reset_valid", 64'(o_store_valid), 64'd0);
    check("reset_credits", 64'(o_credits), 64'(CRED));
    check("reset_err", 64'(o_credit_err), 64'd0);

    // Alternating 2-beat packets from both requesters.
    do_reset();
    want[0] = 1; want[1] = 1; plen[0] = 2; plen[1] = 2; cmode = 1;
    for (int k = 0; k < 30 && issued.size() < 6; k++) cycle();
    check("r34_count", 64'(issued.size()), 64'd6);
    for (int j = 0; j < 6 && j < issued.size(); j++) check("r34_order", 64'(issued[j]), 64'(exp34[j]));

    // Credit exhaustion during a 6-beat packet.
    do_reset();
    want[0] = 1; plen[0] = 6; cmode = 0;
    repeat (6) cycle();
    check("r35_beats", 64'(issued.size()), 64'd4);
    check("r35_credits", 64'(o_credits), 64'd0);
    check("r35_ready", 64'(o_req_ready), 64'd0);
    for (int k = 0; k < 2; k++) begin
      cmode = 1; cycle();
      cmode = 0; cycle();
      check("r35_step", 64'(issued.size()), 64'(5 + k));
    end

    // Owner stalls mid-packet while the other requester waits.
    do_reset();
    want[0] = 1; want[1] = 1; plen[0] = 4; plen[1] = 1; cmode = 2;
    cycle();
    stall[0] = 1;
    repeat (3) cycle();
    check("r36_stall", 64'(issued.size()), 64'd1);
    check("r36_busy", 64'(o_busy), 64'd1);
    stall[0] = 0;
    for (int k = 0; k < 15 && issued.size() < 5; k++) cycle();
    check("r36_count", 64'(issued.size()), 64'd5);
    for (int j = 0; j < 5 && j < issued.size(); j++) check("r36_order", 64'(issued[j]), 64'(exp36[j]));

    // Return and issue in the same cycle at one credit.
    do_reset();
    want[0] = 1; plen[0] = 8; cmode = 0;
    repeat (3) cycle();
    check("r37_pre", 64'(o_credits), 64'd1);
    cmode = 1;
    cycle();
    check("r37_credits", 64'(o_credits), 64'd1);
    check("r37_fired", 64'(issued.size()), 64'd4);

    // Overflowing return while full.
    do_reset();
    cmode = 4; i_store_credit = 1'b1;
    cycle();
    i_store_credit = 1'b0;
    check("r38_credits", 64'(o_credits), 64'(CRED));
    check("r38_err", 64'(o_credit_err), 64'd1);
    repeat (3) cycle();
    check("r38_sticky", 64'(o_credit_err), 64'd1);
    do_reset();
    check("r38_cleared", 64'(o_credit_err), 64'd0);

    // Reset during the 2nd beat of a 4-beat packet.
    do_reset();
    want[0] = 1; plen[0] = 4; cmode = 2;
    cycle();
    drive();
    #2;
    i_reset = 1'b1;
    #1;
    check("r39_valid", 64'(o_store_valid), 64'd0);
    check("r39_ready", 64'(o_req_ready), 64'd0);
    check("r39_busy", 64'(o_busy), 64'd0);
    check("r39_owner_rst", 64'(o_store_owner), 64'd0);
    check("r39_credits", 64'(o_credits), 64'(CRED));
    @(posedge clk);
    #1;
    model_reset();
    i_reset = 1'b0;
    want[1] = 1; plen[1] = 1;
    cycle();
    check("r39_count", 64'(issued.size()), 64'd1);
    check("r39_first", issued.size() > 0 ? 64'(issued[0]) : 64'd99, 64'd1);

    // Randomized traffic.
    do_reset();
    rand_mode = 1; cmode = 3;
    want[0] = 1; want[1] = 1;
    plen[0] = $urandom_range(1, 4); plen[1] = $urandom_range(1, 4);
    repeat (3000) begin
      if ($urandom_range(0, 49) == 0) begin
        int r;
        r = $urandom_range(0, 1);
        want[r] = !want[r];
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
